// File: rtl/draw_rect_img.sv
// Overlays an image-ROM rectangle on a VGA pixel stream. The rectangle
// position is latched from the mouse bus once per frame (on the rising edge
// of vblnk), and the stream is delayed two clocks to line up with ROM data.

`ifndef MOUSE_BUS_SIZE
`define MOUSE_BUS_SIZE 24
`endif
`ifndef MOUSE_XPOS
`define MOUSE_XPOS(bus) bus[23:12]
`endif
`ifndef MOUSE_YPOS
`define MOUSE_YPOS(bus) bus[11:0]
`endif

module draw_rect_img #(
  parameter int          RECT_W = 48,
  parameter int          RECT_H = 64,
  parameter logic [11:0] TRANSP = 12'h000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`MOUSE_BUS_SIZE-1:0] mouse_in,
  input  logic [10:0]                hcount_in,
  input  logic [10:0]                vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic [11:0]                rgb_in,
  input  logic [11:0]                rgb_pixel,
  output logic [11:0]                pixel_addr,
  output logic [10:0]                hcount_out,
  output logic [10:0]                vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [11:0]                rgb_out
);

  logic [11:0] xpos_in, ypos_in;
  logic [11:0] xlat, ylat;
  logic        vblnk_prev;

  logic [11:0] h12, v12;
  logic        in_rect_nxt;
  logic [11:0] addr_nxt;

  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [11:0] rgb_s1;
  logic        in_rect_s1;

  assign xpos_in = `MOUSE_XPOS(mouse_in);
  assign ypos_in = `MOUSE_YPOS(mouse_in);

  // Latch the mouse position on the rising edge of vblnk so it is frozen for the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      xlat       <= '0;
      ylat       <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        xlat <= xpos_in;
        ylat <= ypos_in;
      end
    end
  end

  // Hit test and ROM address in 12-bit unsigned space; positions >= 2048 fail the lower-bound test.
  always_comb begin
    h12         = {1'b0, hcount_in};
    v12         = {1'b0, vcount_in};
    in_rect_nxt = (h12 >= xlat) && (h12 < xlat + 12'(RECT_W)) &&
                  (v12 >= ylat) && (v12 < ylat + 12'(RECT_H));
    addr_nxt    = in_rect_nxt ? {6'(v12 - ylat), 6'(h12 - xlat)} : '0;
  end

  // Stage 1: register timing, background colour, hit flag and ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_s1  <= '0;
      vcount_s1  <= '0;
      hsync_s1   <= 1'b0;
      vsync_s1   <= 1'b0;
      hblnk_s1   <= 1'b0;
      vblnk_s1   <= 1'b0;
      rgb_s1     <= '0;
      in_rect_s1 <= 1'b0;
      pixel_addr <= '0;
    end else begin
      hcount_s1  <= hcount_in;
      vcount_s1  <= vcount_in;
      hsync_s1   <= hsync_in;
      vsync_s1   <= vsync_in;
      hblnk_s1   <= hblnk_in;
      vblnk_s1   <= vblnk_in;
      rgb_s1     <= rgb_in;
      in_rect_s1 <= in_rect_nxt;
      pixel_addr <= addr_nxt;
    end
  end

  // Stage 2: forward timing and select blank / ROM pixel / background.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      if (hblnk_s1 || vblnk_s1)
        rgb_out <= '0;
      else if (in_rect_s1 && (rgb_pixel != TRANSP))
        rgb_out <= rgb_pixel;
      else
        rgb_out <= rgb_s1;
    end
  end

endmodule

// File: tb/tb_draw_rect_img.sv
// Directed bench for draw_rect_img: table of held pixel vectors plus
// sequences for frame latching, clipping, pipeline alignment and reset.

`ifndef MOUSE_BUS_SIZE
`define MOUSE_BUS_SIZE 24
`endif

module tb_draw_rect_img;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic [`MOUSE_BUS_SIZE-1:0] mouse_in;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, rgb_pixel;
  logic [11:0] pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic        rom_force;
  logic [11:0] rom_val;

  int checks = 0;
  int errors = 0;

  assign mouse_in = {xpos, ypos};

  always #5 clk = ~clk;

  draw_rect_img #(.RECT_W(48), .RECT_H(64), .TRANSP(12'h000)) dut (
    .clk(clk), .rst(rst), .mouse_in(mouse_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct {
    logic [10:0] h, v;
    logic        hb, vb;
    logic [11:0] rgb;
    logic        force_rom;
    logic [11:0] rom;
    logic [11:0] exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  typedef struct packed {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } tim_t;

  vec_t tbl[11];
  tim_t rec[200];

  // ROM model: data for the address registered at the previous edge, address ^ 0x800 unless forced.
  task automatic tick();
    @(posedge clk);
    #1;
    rgb_pixel = rom_force ? rom_val : (pixel_addr ^ 12'h800);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [10:0] h, input logic [10:0] v, input logic hb,
                      input logic vb, input logic [11:0] rgb);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    repeat (3) tick();
  endtask

  task automatic pulse_vblnk();
    vblnk_in = 1'b0; tick();
    vblnk_in = 1'b1; tick();
    vblnk_in = 1'b0; tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
               rgb_out, pixel_addr}, '0);
  endtask

  initial begin
    //            h    v    hb    vb    rgb     frc   rom     addr     rgb_out
    tbl[0]  = '{ 99, 200, 1'b0, 1'b0, 12'h123, 1'b0, 12'h0, 12'h000, 12'h123};
    tbl[1]  = '{100, 200, 1'b0, 1'b0, 12'h123, 1'b0, 12'h0, 12'h000, 12'h800};
    tbl[2]  = '{147, 200, 1'b0, 1'b0, 12'h123, 1'b0, 12'h0, 12'h02F, 12'h82F};
    tbl[3]  = '{148, 200, 1'b0, 1'b0, 12'h456, 1'b0, 12'h0, 12'h000, 12'h456};
    tbl[4]  = '{110, 263, 1'b0, 1'b0, 12'h456, 1'b0, 12'h0, 12'hFCA, 12'h7CA};
    tbl[5]  = '{110, 264, 1'b0, 1'b0, 12'h789, 1'b0, 12'h0, 12'h000, 12'h789};
    tbl[6]  = '{110, 199, 1'b0, 1'b0, 12'h789, 1'b0, 12'h0, 12'h000, 12'h789};
    tbl[7]  = '{120, 210, 1'b1, 1'b0, 12'h789, 1'b0, 12'h0, 12'h294, 12'h000};
    tbl[8]  = '{120, 210, 1'b0, 1'b1, 12'h789, 1'b0, 12'h0, 12'h294, 12'h000};
    tbl[9]  = '{120, 210, 1'b0, 1'b0, 12'hABC, 1'b1, 12'h000, 12'h294, 12'hABC};
    tbl[10] = '{120, 210, 1'b0, 1'b0, 12'hABC, 1'b1, 12'h0F0, 12'h294, 12'h0F0};

    rom_force = 1'b0; rom_val = '0; rgb_pixel = '0;
    xpos = 12'd100; ypos = 12'd200;
    hcount_in = 11'd123; vcount_in = 11'd45; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'hFFF;

    // Reset clears everything.
    rst = 1'b1;
    tick(); tick();
    chk_all_zero("reset_outputs");
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Before any vblnk rise the rectangle sits at (0,0).
    rst = 1'b0;
    hold(5, 3, 1'b0, 1'b0, 12'h111);
    chk("origin_addr", pixel_addr, 12'h0C5);
    chk("origin_rgb", rgb_out, 12'h8C5);

    // Latch (100,200) and run the table.
    pulse_vblnk();
    foreach (tbl[i]) begin
      rom_force = tbl[i].force_rom;
      rom_val   = tbl[i].rom;
      hold(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb);
      chk($sformatf("tbl%0d_addr", i), pixel_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_rgb", i), rgb_out, tbl[i].exp_rgb);
      chk($sformatf("tbl%0d_timing", i), {hcount_out, vcount_out, hblnk_out, vblnk_out},
          {tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb});
    end
    rom_force = 1'b0;

    // Mid-frame mouse move is ignored until the next vblnk rise.
    xpos = 12'd300;
    hold(105, 200, 1'b0, 1'b0, 12'h222);
    chk("midframe_old_addr", pixel_addr, 12'h005);
    chk("midframe_old_rgb", rgb_out, 12'h805);
    hold(305, 200, 1'b0, 1'b0, 12'h222);
    chk("midframe_new_pos_addr", pixel_addr, 12'h000);
    chk("midframe_new_pos_rgb", rgb_out, 12'h222);
    pulse_vblnk();
    hold(305, 200, 1'b0, 1'b0, 12'h222);
    chk("moved_addr", pixel_addr, 12'h005);
    chk("moved_rgb", rgb_out, 12'h805);
    hold(105, 200, 1'b0, 1'b0, 12'h333);
    chk("moved_old_rgb", rgb_out, 12'h333);

    // Mouse change on the very cycle vblnk rises: that value is captured.
    vblnk_in = 1'b0; tick();
    xpos = 12'd400; vblnk_in = 1'b1; tick();
    xpos = 12'd500; vblnk_in = 1'b0; tick();
    hold(405, 200, 1'b0, 1'b0, 12'h444);
    chk("coincide_addr", pixel_addr, 12'h005);
    hold(505, 200, 1'b0, 1'b0, 12'h444);
    chk("coincide_other_rgb", rgb_out, 12'h444);

    // Off-screen position on 800x600: nothing drawn, no wrap to the left/top.
    xpos = 12'd1000; ypos = 12'd740;
    pulse_vblnk();
    rgb_in = 12'h321;
    foreach (rec[r]) begin
      if (r >= 3) break;
      vcount_in = (r == 0) ? 11'd0 : (r == 1) ? 11'd4 : 11'd599;
      for (int h = 0; h < 800; h += 7) begin
        hcount_in = 11'(h);
        tick();
        if (h >= 14) begin
          chk("offscreen_addr", pixel_addr, 12'h000);
          chk("offscreen_rgb", rgb_out, 12'h321);
        end
      end
    end

    // Random timing stream with an unreachable position: outputs are inputs delayed 2 clk.
    xpos = 12'd3000; ypos = 12'd3000;
    pulse_vblnk();
    for (int i = 0; i < 200; i++) begin
      rec[i] = '{h: 11'($urandom), v: 11'($urandom), hs: 1'($urandom), vs: 1'($urandom),
                 hb: 1'($urandom), vb: 1'($urandom), rgb: 12'($urandom)};
      hcount_in = rec[i].h; vcount_in = rec[i].v;
      hsync_in = rec[i].hs; vsync_in = rec[i].vs;
      hblnk_in = rec[i].hb; vblnk_in = rec[i].vb; rgb_in = rec[i].rgb;
      tick();
      if (i >= 1) begin
        chk("stream_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
            {rec[i-1].h, rec[i-1].v, rec[i-1].hs, rec[i-1].vs, rec[i-1].hb, rec[i-1].vb});
        chk("stream_rgb", rgb_out, (rec[i-1].hb || rec[i-1].vb) ? 12'h000 : rec[i-1].rgb);
        chk("stream_addr", pixel_addr, 12'h000);
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    tick(); tick();

    // Mid-line reset: immediate clear, 2-cycle resume, position back at (0,0).
    xpos = 12'd100; ypos = 12'd200;
    pulse_vblnk();
    hold(120, 210, 1'b0, 1'b0, 12'h555);
    chk("prereset_addr", pixel_addr, 12'h294);
    hsync_in = 1'b1;
    rst = 1'b1;
    tick();
    chk_all_zero("midline_reset");
    hcount_in = 11'd5; vcount_in = 11'd3; hsync_in = 1'b0;
    rst = 1'b0;
    tick();
    chk("resume_1clk_hcount", hcount_out, 11'd0);
    chk("resume_1clk_rgb", rgb_out, 12'h000);
    tick();
    chk("resume_2clk_timing", {hcount_out, vcount_out}, {11'd5, 11'd3});
    chk("postreset_addr", pixel_addr, 12'h0C5);
    chk("postreset_rgb", rgb_out, 12'h8C5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_rect_img.md
DRAW_RECT_IMG -- requirements
Module: draw_rect_img

Interface
REQ-001 Parameter RECT_W, default 48, rectangle width in pixels (1..64).
REQ-002 Parameter RECT_H, default 64, rectangle height in pixels (1..64).
REQ-003 Parameter TRANSP, default 12'h000, ROM colour treated as transparent.
REQ-004 clk  in  1  pixel clock; the only clock in the block.
REQ-005 rst  in  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-006 mouse_in  in  `MOUSE_BUS_SIZE  position bus from draw_rect_ctl, split with the codebase mouse-bus macro; only xpos_in[11:0] and ypos_in[11:0] are used.
REQ-007 hcount_in, vcount_in  in  11 each  current VGA pixel coordinates.
REQ-008 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing strobes.
REQ-009 rgb_in  in  12  background pixel colour.
REQ-010 rgb_pixel  in  12  image ROM data, valid one clk after pixel_addr.
REQ-011 pixel_addr  out  12  image ROM address {row[5:0], col[5:0]}.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  as inputs  delayed VGA stream with the rectangle overlaid.

Function
REQ-013 The block SHALL capture xpos_in/ypos_in into internal xlat/ylat on the cycle vblnk_in rises (vblnk_in=1 while its previous-cycle value was 0), so that the position is constant for a whole visible frame.
REQ-014 xlat/ylat SHALL hold between captures, and mid-frame changes of mouse_in SHALL NOT affect the current frame.
REQ-015 Stage 1 (cycle N+1) SHALL register all timing inputs, rgb_in, and in_rect = (hcount_in >= xlat) && (hcount_in < xlat+RECT_W) && (vcount_in >= ylat) && (vcount_in < ylat+RECT_H).
REQ-016 Comparisons SHALL use 12-bit unsigned arithmetic, so xlat+RECT_W cannot wrap and rectangles overlapping the right or bottom edge are clipped naturally.
REQ-017 Stage 1 SHALL register pixel_addr = {vcount_in-ylat [5:0], hcount_in-xlat [5:0]} when in_rect is true, and 12'h000 otherwise.
REQ-018 Stage 2 (cycle N+2) SHALL forward the stage-1 timing signals to the outputs unchanged.
REQ-019 rgb_out SHALL be 12'h000 when the stage-1 hblnk or vblnk is 1.
REQ-020 Otherwise, rgb_out SHALL be rgb_pixel when the stage-1 in_rect is 1 and rgb_pixel != TRANSP.
REQ-021 In all remaining cases, rgb_out SHALL be the stage-1 rgb_in.
REQ-022 Total latency from every input to every output SHALL be exactly 2 clk cycles, and all outputs SHALL be mutually aligned.
REQ-023 Coordinates of xpos_in >= 2048 or ypos_in >= 2048 SHALL never match any hcount/vcount, so nothing is drawn.
REQ-024 When a vblnk rising edge coincides with a mouse_in change, the value present on that cycle SHALL be captured.
REQ-025 The block SHALL contain no state machine beyond the edge detector and the two pipeline stages, and SHALL insert no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1, all outputs, both pipeline stages, xlat, ylat and the vblnk edge register SHALL be 0 on the next clk edge.
REQ-027 After rst deasserts, the first vblnk rising edge SHALL load a position, and until then the rectangle SHALL be drawn at (0,0).
REQ-028 Reset asserted mid-frame SHALL take effect on the next edge, and outputs SHALL resume two cycles after release with the position held at (0,0) until the next vblnk rise.

Verification
REQ-029 Set xpos=100, ypos=200, pulse vblnk low->high, then sweep hcount 99..148 on vcount=200 -> in_rect is 1 exactly for hcount 100..147; pixel_addr is 0x000..0x02F; rgb_out equals ROM data 2 cycles later.
REQ-030 Set rgb_pixel=TRANSP=12'h000 and rgb_in=12'hABC inside the rectangle -> rgb_out=12'hABC.
REQ-031 Change xpos from 100 to 300 while vblnk=0 in mid-frame -> the drawn position stays at 100 until the next vblnk rise, then moves to 300.
REQ-032 Set xpos=1000, ypos=740 on an 800x600 timing -> no visible pixel is overlaid; pixel_addr stays 0; there is no wrap to the left edge.
REQ-033 Drive a random timing stream -> every *_out equals the corresponding *_in delayed by exactly 2 cycles, and rgb_out=0 whenever the delayed hblnk or vblnk is 1.
REQ-034 Assert rst for 1 cycle mid-line -> all outputs are 0 on the next edge; the rectangle is at (0,0) until a vblnk rise loads the new position.
